// File: rtl/seq_shift_unit.sv
// seq_shift_unit
//   Multi-cycle shift/rotate unit. An accepted start captures the operand,
//   distance, direction and mode; the working register is then shifted by up
//   to STEP positions per clock until the requested distance is consumed.
//
// Ports
//   clk           clock, rising edge
//   clear_n       asynchronous active-low reset
//   start         request; accepted in IDLE or DONE, ignored while busy
//   data_in       operand (WIDTH)
//   shift_amount  distance 0..WIDTH-1 (AW)
//   direction     0 = right, 1 = left
//   mode          00 logical, 01 arithmetic, 10 rotate, 11 logical
//   data_out      working / result register (WIDTH)
//   carry_out     last bit shifted or rotated out
//   zero          data_out == 0
//   busy          operation in progress
//   done          one-cycle completion pulse
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for start, result held
// S_SHIFT | shifting, remaining != 0
// S_DONE  | result valid for one cycle; start may be re-accepted
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    shift_amount,
  input  logic             direction,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  state_t                state, state_nxt;
  logic   [AW-1:0]       remaining;
  logic                  dir_q;
  logic   [1:0]          mode_q;
  logic                  accept;

  logic   [AW-1:0]       step_n, step_m1;
  logic   [WIDTH-1:0]    shifted;
  logic                  carry_nxt;
  logic   [2*WIDTH-1:0]  dbl, dbl_r, dbl_l;
  logic signed [WIDTH-1:0] sra;
  logic   [WIDTH-1:0]    probe_r, probe_l;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (shift_amount != '0) ? S_SHIFT : S_DONE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (remaining == step_n) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One step of n = min(remaining, STEP) positions.
  always_comb begin
    step_n  = (remaining < STEP_A) ? remaining : STEP_A;
    step_m1 = step_n - AW'(1);
    dbl     = {data_out, data_out};
    dbl_r   = dbl >> step_n;
    dbl_l   = dbl << step_n;
    sra     = $signed(data_out) >>> step_n;
    case (mode_q)
      2'b01:   shifted = direction_sel(dir_q, data_out << step_n, sra);
      2'b10:   shifted = direction_sel(dir_q, dbl_l[2*WIDTH-1:WIDTH], dbl_r[WIDTH-1:0]);
      default: shifted = direction_sel(dir_q, data_out << step_n, data_out >> step_n);
    endcase
    // Move the last departing bit (n-1 for right, WIDTH-n for left) to an end.
    probe_r   = data_out >> step_m1;
    probe_l   = data_out << step_m1;
    carry_nxt = dir_q ? probe_l[WIDTH-1] : probe_r[0];
  end

  function automatic logic [WIDTH-1:0] direction_sel(input logic left,
                                                     input logic [WIDTH-1:0] l_val,
                                                     input logic [WIDTH-1:0] r_val);
    return left ? l_val : r_val;
  endfunction

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      remaining <= '0;
      dir_q     <= 1'b0;
      mode_q    <= 2'b00;
    end else if (accept) begin
      data_out  <= data_in;
      carry_out <= 1'b0;
      remaining <= shift_amount;
      dir_q     <= direction;
      mode_q    <= mode;
    end else if (state == S_SHIFT) begin
      data_out  <= shifted;
      carry_out <= carry_nxt;
      remaining <= remaining - step_n;
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);
  assign zero = (data_out == '0);

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Parametrised, multi-cycle shift/rotate unit: the successor to the fixed 8-bit shifter. It captures an operand on a start strobe and shifts it by up to STEP bit positions per clock until the requested amount is reached. It supports logical, arithmetic and rotate modes in both directions, and reports carry-out, zero and completion. It sits beside the ALU in the datapath and is driven by the control FSM through a start/busy/done handshake.

## Interface
- WIDTH, 8: data width. Power of 2, ≥ 4.
- STEP, 1: maximum bit positions shifted per cycle. Range 1..WIDTH-1.
- AW (localparam), $clog2(WIDTH): shift_amount width.

- clk  in  1  clock; all state changes on the rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a new operation. Sampled only when not busy.
- data_in  in  WIDTH  operand, captured on an accepted start.
- shift_amount  in  AW  shift distance, 0..WIDTH-1, captured on an accepted start.
- direction  in  1  0 = right, 1 = left; captured on an accepted start.
- mode  in  2  00 = logical, 01 = arithmetic, 10 = rotate, 11 = logical (reserved).
- data_out  out  WIDTH  working/result register.
- carry_out  out  1  last bit shifted or rotated out.
- zero  out  1  data_out == 0. Valid while done = 1 and held afterwards.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, DONE. Registers: data_out, carry_out, remaining count (AW bits), and captured direction/mode.
- Start acceptance: start is accepted in IDLE or DONE (this allows back-to-back operations). It is ignored in SHIFT. All inputs other than start are don't-care except at the accepting edge.
- On an accepted start:
  - data_out ← data_in, carry_out ← 0, remaining ← shift_amount.
  - Next state is SHIFT if shift_amount ≠ 0, otherwise DONE.
- Each SHIFT edge:
  - Shift by n = min(remaining, STEP), then remaining ← remaining − n.
  - carry_out ← the last bit leaving the register in that step:
    - right shift: the bit at position n−1 before the step;
    - left shift: the bit at position WIDTH−n before the step.
  - When remaining reaches 0 the next state is DONE.
- Fill rules:
  - Logical: zero fill, both directions.
  - Arithmetic right: MSB replicated. Arithmetic left: identical to logical left.
  - Rotate: bits leaving one end enter the other end. carry_out follows the same rule as for shifts.
- Result: the final data_out equals a single shift by shift_amount. The result is independent of STEP apart from latency.
- DONE: lasts one cycle, then returns to IDLE. A start accepted in DONE behaves exactly as a start accepted in IDLE.
- Outputs data_out, carry_out and zero hold their values in IDLE until the next accepted start.
- Reset: when clear_n is low, asynchronously force state = IDLE and data_out, carry_out, remaining, busy, done = 0; zero = 1. This applies mid-operation as well; the aborted operation produces no done pulse.

## Timing
- Let E0 be the edge that accepts start, and k = ceil(shift_amount / STEP).
- busy: high from E0 to E0+k, i.e. for k cycles. It is never high for shift_amount = 0.
- done: high for exactly the one cycle following edge E0+k. busy = 0 during that cycle.
- Latency start→done is k+1 cycles. For shift_amount = 0, done is asserted the cycle after E0.
- done and busy are never both 1.
- A start presented with clear_n low is ignored. The first start can be accepted at the first rising edge after clear_n deasserts.

## Test plan
- WIDTH=8, STEP=1: data_in=10101010, amt=3, left, logical → busy for 3 cycles, then done pulse; data_out=01010000, carry_out=1, zero=0.
- WIDTH=8, STEP=1: data_in=10101010, amt=2, right, arithmetic → 11101010, carry_out=1. The same operation with logical mode → 00101010, carry_out=1.
- WIDTH=8: data_in=10101010, amt=3, right, rotate → 01010101, carry_out=0. amt=0 → data_out=10101010, done one cycle after start, busy never asserted.
- WIDTH=8, STEP=1: data_in=10101010, amt=7, left, logical → 00000000, carry_out=1, zero=1, done at E0+7. Then a start in the DONE cycle with amt=1 → accepted, and the new result follows.
- WIDTH=16, STEP=4: data_in=16'h8001, amt=9, right, logical → step sizes 4, 4, 1 (3 busy cycles); data_out=16'h0040, carry_out=0. Toggling start and data_in during busy has no effect.
- Mid-operation reset: WIDTH=8, STEP=1, amt=6. Pull clear_n low at cycle 3 → all outputs 0 immediately, zero=1, no done pulse. After release, a new start completes normally.
